// File: rtl/hc595_pkg.sv
// rtl/hc595_pkg.sv - shared FSM state type and default constants for the 595 chain controller
package hc595_pkg;

    localparam int CHAIN_BITS_DEF = 14;
    localparam int DIV_DEF        = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        LATCH = 2'd2
    } state_e;

endpackage

// File: rtl/hc595_chain_ctrl_if.sv
// rtl/hc595_chain_ctrl_if.sv - frame handshake and 595 pin bundle
interface hc595_chain_ctrl_if #(
    parameter int CHAIN_BITS = hc595_pkg::CHAIN_BITS_DEF
);
    logic [CHAIN_BITS-1:0] frame_data;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  out_en;
    logic                  busy;
    logic                  ds;
    logic                  shcp;
    logic                  stcp;
    logic                  oe;

    modport master (
        output frame_data, frame_valid, out_en,
        input  frame_ready, busy, ds, shcp, stcp, oe
    );

    modport slave (
        input  frame_data, frame_valid, out_en,
        output frame_ready, busy, ds, shcp, stcp, oe
    );
endinterface

// File: rtl/hc595_bit_timer.sv
// rtl/hc595_bit_timer.sv - per-bit phase counter, registered shcp level and end-of-bit/latch strobes
module hc595_bit_timer
    import hc595_pkg::*;
#(
    parameter int DIV = DIV_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_shift_i,
    input  logic in_latch_i,
    input  logic next_shift_i,
    output logic shcp_o,
    output logic end_bit_o,
    output logic end_latch_o
);
    localparam int PW = $clog2(2 * DIV);
    localparam logic [PW-1:0] LAST_SHIFT = PW'(2 * DIV - 1);
    localparam logic [PW-1:0] LAST_LATCH = PW'(DIV - 1);
    localparam logic [PW-1:0] HALF       = PW'(DIV);

    logic [PW-1:0] phase_q, phase_d;
    logic          shcp_q, shcp_d;

    assign end_bit_o   = in_shift_i && (phase_q == LAST_SHIFT);
    assign end_latch_o = in_latch_i && (phase_q == LAST_LATCH);
    assign shcp_o      = shcp_q;

    // Phase restarts at zero on every bit/latch boundary and idles at zero.
    always_comb begin
        phase_d = '0;
        if ((in_shift_i || in_latch_i) && !end_bit_o && !end_latch_o) begin
            phase_d = phase_q + 1'b1;
        end
        shcp_d = next_shift_i && (phase_d >= HALF);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q <= '0;
            shcp_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            shcp_q  <= shcp_d;
        end
    end
endmodule

// File: rtl/hc595_chain_ctrl.sv
// rtl/hc595_chain_ctrl.sv - serialises one frame into a 74HC595 chain, then pulses the storage latch
module hc595_chain_ctrl
    import hc595_pkg::*;
#(
    parameter int CHAIN_BITS = CHAIN_BITS_DEF,
    parameter int DIV        = DIV_DEF,
    parameter int MSB_FIRST  = 1
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    hc595_chain_ctrl_if.slave  bus
);
    localparam int KW = $clog2(CHAIN_BITS);
    localparam logic [KW-1:0] LAST_BIT = KW'(CHAIN_BITS - 1);

    state_e                state_q, state_d;
    logic [KW-1:0]         bit_q, bit_d;
    logic [CHAIN_BITS-1:0] sreg_q, sreg_d;
    logic                  ds_q, ds_d;
    logic                  stcp_q, stcp_d;
    logic                  busy_q, busy_d;
    logic                  ready_q, ready_d;
    logic                  oe_q, oe_d;
    logic                  latched_q, latched_d;
    logic                  shcp, end_bit, end_latch;
    logic                  accept;

    function automatic logic head(input logic [CHAIN_BITS-1:0] v);
        return (MSB_FIRST != 0) ? v[CHAIN_BITS-1] : v[0];
    endfunction

    hc595_bit_timer #(.DIV(DIV)) u_timer (
        .clk_i        (sys_clk),
        .rst_i        (sys_rst),
        .in_shift_i   (state_q == SHIFT),
        .in_latch_i   (state_q == LATCH),
        .next_shift_i (state_d == SHIFT),
        .shcp_o       (shcp),
        .end_bit_o    (end_bit),
        .end_latch_o  (end_latch)
    );

    assign accept = bus.frame_valid && (state_q == IDLE);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            bit_q     <= '0;
            sreg_q    <= '0;
            ds_q      <= 1'b0;
            stcp_q    <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b1;
            oe_q      <= 1'b1;
            latched_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_q     <= bit_d;
            sreg_q    <= sreg_d;
            ds_q      <= ds_d;
            stcp_q    <= stcp_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            oe_q      <= oe_d;
            latched_q <= latched_d;
        end
    end

    // The shift register always presents the bit on the wire at its head end.
    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        case (state_q)
            IDLE: begin
                bit_d = '0;
                if (accept) begin
                    state_d = SHIFT;
                    sreg_d  = bus.frame_data;
                end
            end
            SHIFT: begin
                if (end_bit) begin
                    if (bit_q == LAST_BIT) begin
                        state_d = LATCH;
                    end else begin
                        bit_d  = bit_q + 1'b1;
                        sreg_d = (MSB_FIRST != 0) ? (sreg_q << 1) : (sreg_q >> 1);
                    end
                end
            end
            LATCH: begin
                if (end_latch) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from next-state so every pin comes straight off a flop.
    always_comb begin
        ds_d      = (state_d == SHIFT) ? head(sreg_d) : ds_q;
        stcp_d    = (state_d == LATCH);
        busy_d    = (state_d != IDLE);
        ready_d   = (state_d == IDLE);
        latched_d = latched_q | ((state_q == LATCH) && end_latch);
        oe_d      = latched_q ? ~bus.out_en : 1'b1;
    end

    assign bus.ds          = ds_q;
    assign bus.shcp        = shcp;
    assign bus.stcp        = stcp_q;
    assign bus.busy        = busy_q;
    assign bus.frame_ready = ready_q;
    assign bus.oe          = oe_q;
endmodule

// File: tb/tb_hc595_chain_ctrl.sv
// tb/tb_hc595_chain_ctrl.sv - two-instance cycle-level reference check of hc595_chain_ctrl
module tb_hc595_chain_ctrl;
    localparam int CB = 14;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CB-1:0] fdata = '0;
    logic          fvalid = 1'b0;
    logic          oen = 1'b1;

    always #5 clk = ~clk;

    hc595_chain_ctrl_if #(.CHAIN_BITS(CB)) if0 ();
    hc595_chain_ctrl_if #(.CHAIN_BITS(CB)) if1 ();

    assign if0.frame_data  = fdata;
    assign if0.frame_valid = fvalid;
    assign if0.out_en      = oen;
    assign if1.frame_data  = fdata;
    assign if1.frame_valid = fvalid;
    assign if1.out_en      = oen;

    hc595_chain_ctrl #(.CHAIN_BITS(CB), .DIV(2), .MSB_FIRST(1)) u0 (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (if0)
    );

    hc595_chain_ctrl #(.CHAIN_BITS(CB), .DIV(1), .MSB_FIRST(0)) u1 (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (if1)
    );

    // {ds, shcp, stcp, oe, busy, frame_ready}
    logic [5:0] obs [2];
    assign obs[0] = {if0.ds, if0.shcp, if0.stcp, if0.oe, if0.busy, if0.frame_ready};
    assign obs[1] = {if1.ds, if1.shcp, if1.stcp, if1.oe, if1.busy, if1.frame_ready};

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic logic bit_at(input int i, input logic [CB-1:0] f, input int k);
        logic [CB-1:0] v;
        v = f;
        return (i == 0) ? v[CB-1-k] : v[k];
    endfunction

    // Reference: a frame accepted at edge T owns cycles T+1 .. T+2*DIV*CB+DIV.
    bit            m_act  [2];
    int            m_t    [2];
    logic [CB-1:0] m_fr   [2];
    logic          m_last [2];
    bit            m_done [2];
    logic          m_oe   [2];

    function automatic logic [5:0] model_out(input int i);
        int d, ls, dv, k, p;
        dv = div_of(i);
        ls = 2 * dv * CB;
        if (m_act[i]) begin
            d = cyc - m_t[i] + 1;
            if (d <= ls) begin
                k = (d - 1) / (2 * dv);
                p = (d - 1) % (2 * dv);
                return {bit_at(i, m_fr[i], k), (p >= dv), 1'b0, m_oe[i], 1'b1, 1'b0};
            end
            return {bit_at(i, m_fr[i], CB - 1), 1'b0, 1'b1, m_oe[i], 1'b1, 1'b0};
        end
        return {m_last[i], 1'b0, 1'b0, m_oe[i], 1'b0, 1'b1};
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_t[i] = 0; m_fr[i] = '0; m_last[i] = 1'b0; m_done[i] = 0; m_oe[i] = 1'b1;
        end
        forever begin
            @(posedge clk);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    m_act[i] = 0; m_done[i] = 0; m_last[i] = 1'b0; m_oe[i] = 1'b1;
                end else begin
                    m_oe[i] = m_done[i] ? ~oen : 1'b1;
                    if (m_act[i] && (cyc - m_t[i] == 2 * div_of(i) * CB + div_of(i))) begin
                        m_act[i]  = 0;
                        m_done[i] = 1;
                        m_last[i] = bit_at(i, m_fr[i], CB - 1);
                    end else if (!m_act[i] && fvalid) begin
                        m_act[i] = 1;
                        m_t[i]   = cyc;
                        m_fr[i]  = fdata;
                    end
                end
            end
        end
    end

    // Observation counters used by the literal checks.
    int          rises [2], stcps [2], acc_cnt [2], acc_edge [2], stcp_rel [2], ready_rel [2];
    logic [63:0] dsbits [2];
    logic        p_shcp [2], p_stcp [2], p_ready [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            rises[i] = 0; stcps[i] = 0; acc_cnt[i] = 0; acc_edge[i] = 0;
            stcp_rel[i] = 0; ready_rel[i] = 0; dsbits[i] = '0;
            p_shcp[i] = 1'b0; p_stcp[i] = 1'b0; p_ready[i] = 1'b0;
        end
        forever begin
            logic [5:0] e;
            @(negedge clk);
            if (cyc > 0) begin
                for (int i = 0; i < 2; i++) begin
                    e = model_out(i);
                    chk($sformatf("u%0d.ds@%0d", i, cyc),          {31'd0, obs[i][5]}, {31'd0, e[5]});
                    chk($sformatf("u%0d.shcp@%0d", i, cyc),        {31'd0, obs[i][4]}, {31'd0, e[4]});
                    chk($sformatf("u%0d.stcp@%0d", i, cyc),        {31'd0, obs[i][3]}, {31'd0, e[3]});
                    chk($sformatf("u%0d.oe@%0d", i, cyc),          {31'd0, obs[i][2]}, {31'd0, e[2]});
                    chk($sformatf("u%0d.busy@%0d", i, cyc),        {31'd0, obs[i][1]}, {31'd0, e[1]});
                    chk($sformatf("u%0d.frame_ready@%0d", i, cyc), {31'd0, obs[i][0]}, {31'd0, e[0]});

                    if (obs[i][0] && fvalid && !rst) begin
                        acc_cnt[i]++;
                        acc_edge[i] = cyc + 1;
                    end
                    if (obs[i][4] && !p_shcp[i]) begin
                        rises[i]++;
                        dsbits[i] = {dsbits[i][62:0], obs[i][5]};
                    end
                    if (obs[i][3] && !p_stcp[i]) begin
                        stcps[i]++;
                        stcp_rel[i] = cyc + 1 - acc_edge[i];
                    end
                    if (obs[i][0] && !p_ready[i]) ready_rel[i] = cyc + 1 - acc_edge[i];
                    p_shcp[i]  = obs[i][4];
                    p_stcp[i]  = obs[i][3];
                    p_ready[i] = obs[i][0];
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int base, e1, e2, st0, wait_n;
        step(3);
        chk("reset.ready", {31'd0, if0.frame_ready}, 32'd1);
        chk("reset.oe",    {31'd0, if0.oe},          32'd1);
        chk("reset.ds",    {31'd0, if0.ds},          32'd0);
        chk("reset.busy",  {31'd0, if0.busy},        32'd0);
        rst = 1'b0;
        step(10);
        chk("noframe.oe0", {31'd0, if0.oe}, 32'd1);
        chk("noframe.oe1", {31'd0, if1.oe}, 32'd1);

        for (int i = 0; i < 2; i++) begin
            rises[i] = 0; stcps[i] = 0; dsbits[i] = '0;
        end
        fdata  = 14'h2A5C;
        fvalid = 1'b1;
        step(1);
        fvalid = 1'b0;
        repeat (70) begin
            fdata = CB'($urandom);
            step(1);
        end
        chk("f1.rises0",   rises[0], 32'd14);
        chk("f1.rises1",   rises[1], 32'd14);
        chk("f1.dsseq0",   {18'd0, dsbits[0][13:0]}, {18'd0, 14'b10101001011100});
        chk("f1.dsseq1",   {18'd0, dsbits[1][13:0]}, {18'd0, 14'b00111010010101});
        chk("f1.stcps0",   stcps[0], 32'd1);
        chk("f1.stcps1",   stcps[1], 32'd1);
        chk("f1.stcprel0", stcp_rel[0], 32'd57);
        chk("f1.readyrel0", ready_rel[0], 32'd59);
        chk("f1.stcprel1", stcp_rel[1], 32'd29);
        chk("f1.readyrel1", ready_rel[1], 32'd30);
        chk("f1.oe0", {31'd0, if0.oe}, 32'd0);
        chk("f1.oe1", {31'd0, if1.oe}, 32'd0);

        oen = 1'b0;
        step(1);
        chk("outen_off.oe0", {31'd0, if0.oe}, 32'd1);
        oen = 1'b1;
        step(1);
        chk("outen_on.oe0", {31'd0, if0.oe}, 32'd0);

        rises[0] = 0; stcps[0] = 0;
        base   = acc_cnt[0];
        fdata  = 14'h3FFF;
        fvalid = 1'b1;
        wait_n = 0;
        while (acc_cnt[0] < base + 1 && wait_n < 200) begin step(1); wait_n++; end
        e1    = acc_edge[0];
        fdata = 14'h0001;
        while (acc_cnt[0] < base + 2 && wait_n < 400) begin step(1); wait_n++; end
        e2     = acc_edge[0];
        fvalid = 1'b0;
        chk("b2b.timeout", {31'd0, (acc_cnt[0] >= base + 2)}, 32'd1);
        step(80);
        chk("b2b.gap",    e2 - e1, 32'd59);
        chk("b2b.rises0", rises[0], 32'd28);
        chk("b2b.stcps0", stcps[0], 32'd2);

        st0    = stcps[0];
        fdata  = CB'($urandom);
        fvalid = 1'b1;
        step(1);
        fvalid = 1'b0;
        step(29);
        rst = 1'b1;
        step(1);
        chk("abort.ds",    {31'd0, if0.ds},          32'd0);
        chk("abort.shcp",  {31'd0, if0.shcp},        32'd0);
        chk("abort.stcp",  {31'd0, if0.stcp},        32'd0);
        chk("abort.oe",    {31'd0, if0.oe},          32'd1);
        chk("abort.busy",  {31'd0, if0.busy},        32'd0);
        chk("abort.ready", {31'd0, if0.frame_ready}, 32'd1);
        rst = 1'b0;
        step(30);
        chk("abort.nostcp", stcps[0], st0);
        chk("abort.oehold", {31'd0, if0.oe}, 32'd1);
        fdata  = CB'($urandom);
        fvalid = 1'b1;
        step(1);
        fvalid = 1'b0;
        step(70);
        chk("abort.oe_after_frame", {31'd0, if0.oe}, 32'd0);

        repeat (2000) begin
            fdata  = CB'($urandom);
            fvalid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) oen = ~oen;
            rst = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst    = 1'b0;
        fvalid = 1'b0;
        step(80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
